// File: rtl/dice_pkg.sv
// Shared types and constants for the multi-die roller: field widths,
// pip patterns, the face-to-pip lookup, FSM states and LFSR taps.
package dice_pkg;

    localparam int FACE_W = 3;
    localparam int PIP_W  = 8;

    localparam logic [PIP_W-1:0] PIP_1 = 8'b0000_0010;
    localparam logic [PIP_W-1:0] PIP_2 = 8'b1001_0000;
    localparam logic [PIP_W-1:0] PIP_3 = 8'b1001_0010;
    localparam logic [PIP_W-1:0] PIP_4 = 8'b0110_1100;
    localparam logic [PIP_W-1:0] PIP_5 = 8'b0110_1110;
    localparam logic [PIP_W-1:0] PIP_6 = 8'b1111_1100;

    // Bit indices of taps 16,14,13,11 in a 16-bit Fibonacci LFSR
    localparam int LFSR_TAP_A = 15;
    localparam int LFSR_TAP_B = 13;
    localparam int LFSR_TAP_C = 12;
    localparam int LFSR_TAP_D = 10;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE,
        SHOW
    } state_t;

    // Blank (0) and the unused code 7 both map to an unlit display
    function automatic logic [PIP_W-1:0] face_to_pip(input logic [FACE_W-1:0] f);
        case (f)
            3'd1:    return PIP_1;
            3'd2:    return PIP_2;
            3'd3:    return PIP_3;
            3'd4:    return PIP_4;
            3'd5:    return PIP_5;
            3'd6:    return PIP_6;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/dice_tick_div.sv
// Free-running animation tick divider: counts 0..DIV-1 and pulses tick
// on the wrap cycle. Runs regardless of what the roller FSM is doing.
module dice_tick_div #(
    parameter int DIV = 500000
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_W'(DIV - 1));

    // Next count: wrap to zero on the tick cycle
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Counter register, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/multi_dice_roller.sv
// N-die roller: one shared LFSR, a tick divider and an IDLE/ROLL/SETTLE/SHOW
// FSM. Each die samples its own 3-bit LFSR slice on ticks while rolling.
// Optional macro DICE_HOLD_EN adds a per-die hold mask that freezes dice.
module multi_dice_roller
    import dice_pkg::*;
#(
    parameter int          N_DICE       = 2,
    parameter int          DIV          = 500000,
    parameter int          SETTLE_TICKS = 20,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               roll,
`ifdef DICE_HOLD_EN
    input  logic [N_DICE-1:0]                  hold,
`endif
    output logic [FACE_W*N_DICE-1:0]           face,
    output logic [PIP_W*N_DICE-1:0]            display,
    output logic [$clog2(6*N_DICE+1)-1:0]      sum,
    output logic                               rolling,
    output logic                               done
);

    localparam int SUM_W = $clog2(6 * N_DICE + 1);
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);

    logic              tick;
    logic [15:0]       lfsr_q;
    state_t            state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic              rolling_q;
    logic              done_q;
    logic              update_en;
    logic [FACE_W-1:0] face_q [N_DICE];

    dice_tick_div #(.DIV(DIV)) u_tick_div (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    // LFSR advances every clock so the outcome depends on press timing
    always_ff @(posedge clock) begin
        if (!reset) lfsr_q <= SEED;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[LFSR_TAP_A] ^ lfsr_q[LFSR_TAP_B]
                                           ^ lfsr_q[LFSR_TAP_C] ^ lfsr_q[LFSR_TAP_D]};
    end

    // Next-state logic; re-press always wins over a settle-expiry tick
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            IDLE:    if (roll) state_d = ROLL;
            ROLL: begin
                if (!roll) begin
                    state_d  = SETTLE;
                    settle_d = SET_W'(SETTLE_TICKS);
                end
            end
            SETTLE: begin
                if (roll) begin
                    state_d = ROLL;
                end else if (tick) begin
                    settle_d = settle_q - 1'b1;
                    if (settle_q == SET_W'(1)) state_d = SHOW;
                end
            end
            SHOW:    if (roll) state_d = ROLL;
            default: state_d = IDLE;
        endcase
    end

    // FSM state plus registered rolling decode and the SHOW-entry strobe
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            rolling_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            rolling_q <= (state_d == ROLL) || (state_d == SETTLE);
            done_q    <= (state_q == SETTLE) && (state_d == SHOW);
        end
    end

    // Faces follow the pre-transition state, so a tick on the exit cycle still counts
    assign update_en = tick && ((state_q == ROLL) || (state_q == SETTLE));

    for (genvar gi = 0; gi < N_DICE; gi++) begin : g_die
        logic [FACE_W-1:0] slice;
        logic              hold_bit;

        assign slice = {lfsr_q[(3*gi+2) % 16], lfsr_q[(3*gi+1) % 16], lfsr_q[(3*gi) % 16]};
`ifdef DICE_HOLD_EN
        assign hold_bit = hold[gi];
`else
        assign hold_bit = 1'b0;
`endif

        // Take the slice only when it is a legal face; otherwise keep the old face
        always_ff @(posedge clock) begin
            if (!reset) begin
                face_q[gi] <= '0;
            end else if (update_en && !hold_bit && (slice >= 3'd1) && (slice <= 3'd6)) begin
                face_q[gi] <= slice;
            end
        end

        assign face[FACE_W*gi +: FACE_W]  = face_q[gi];
        assign display[PIP_W*gi +: PIP_W] = face_to_pip(face_q[gi]);
    end

    // Zero-extended sum of the current faces
    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_DICE; i++) begin
            sum_d = sum_d + SUM_W'(face_q[i]);
        end
    end

    // Sum register trails face changes by one clock
    always_ff @(posedge clock) begin
        if (!reset) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign sum     = sum_q;
    assign rolling = rolling_q;
    assign done    = done_q;

endmodule

// File: tb/tb_multi_dice_roller.sv
// Directed bench for multi_dice_roller (DIV=4, SETTLE_TICKS=3, N_DICE=2)
// with a cycle reference model, plus an N_DICE=8 instance for range checks.
module tb_multi_dice_roller;

    localparam int DIV    = 4;
    localparam int SETTLE = 3;

    logic        clock;
    logic        reset;
    logic        roll;
    logic        roll8;
    logic [5:0]  face;
    logic [15:0] display;
    logic [3:0]  sum;
    logic        rolling;
    logic        done;
    logic [23:0] face8;
    logic [63:0] display8;
    logic [5:0]  sum8;
    logic        rolling8;
    logic        done8;
    logic [1:0]  hold;

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    multi_dice_roller #(.N_DICE(2), .DIV(DIV), .SETTLE_TICKS(SETTLE), .SEED(16'hACE1)) dut (
        .clock   (clock),
        .reset   (reset),
        .roll    (roll),
`ifdef DICE_HOLD_EN
        .hold    (hold),
`endif
        .face    (face),
        .display (display),
        .sum     (sum),
        .rolling (rolling),
        .done    (done)
    );

    multi_dice_roller #(.N_DICE(8), .DIV(DIV), .SETTLE_TICKS(SETTLE), .SEED(16'hACE1)) dut8 (
        .clock   (clock),
        .reset   (reset),
        .roll    (roll8),
`ifdef DICE_HOLD_EN
        .hold    (8'h00),
`endif
        .face    (face8),
        .display (display8),
        .sum     (sum8),
        .rolling (rolling8),
        .done    (done8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (N_DICE=2) ----------------
    logic [15:0] m_lfsr;
    int          m_div;
    int          m_state;   // 0 idle, 1 roll, 2 settle, 3 show
    int          m_settle;
    logic [2:0]  m_face [2];
    int          m_sum;
    logic        m_done;
    logic        m_tick;
    logic        m_rolling;
    logic [1:0]  m_hold;

    function automatic logic [2:0] mslice(input logic [15:0] l, input int i);
        return {l[(3*i+2) % 16], l[(3*i+1) % 16], l[(3*i) % 16]};
    endfunction

    assign m_tick    = (m_div == DIV - 1);
    assign m_rolling = (m_state == 1) || (m_state == 2);
`ifdef DICE_HOLD_EN
    assign m_hold = hold;
`else
    assign m_hold = 2'b00;
`endif

    always @(posedge clock) begin
        if (!reset) begin
            m_lfsr   <= 16'hACE1;
            m_div    <= 0;
            m_state  <= 0;
            m_settle <= 0;
            m_face[0] <= 3'd0;
            m_face[1] <= 3'd0;
            m_sum    <= 0;
            m_done   <= 1'b0;
        end else begin
            m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
            m_div  <= m_tick ? 0 : m_div + 1;
            m_done <= 1'b0;
            m_sum  <= 32'(m_face[0]) + 32'(m_face[1]);
            for (int i = 0; i < 2; i++) begin
                if (m_tick && m_rolling && !m_hold[i] &&
                    mslice(m_lfsr, i) >= 3'd1 && mslice(m_lfsr, i) <= 3'd6)
                    m_face[i] <= mslice(m_lfsr, i);
            end
            case (m_state)
                0: if (roll) m_state <= 1;
                1: if (!roll) begin m_state <= 2; m_settle <= SETTLE; end
                2: begin
                    if (roll) m_state <= 1;
                    else if (m_tick) begin
                        m_settle <= m_settle - 1;
                        if (m_settle == 1) begin m_state <= 3; m_done <= 1'b1; end
                    end
                end
                default: if (roll) m_state <= 1;
            endcase
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        check("done", 32'(done), 32'(m_done));
        check("rolling", 32'(rolling), 32'(m_rolling));
        check("face", 32'(face), {26'd0, m_face[1], m_face[0]});
        check("sum", 32'(sum), 32'(m_sum));
        if (done) n_done++;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 60) begin
            step();
            cyc++;
        end
        if (!done) check("done_timeout", 32'(0), 32'(1));
    endtask

    logic [7:0] pip_tab [8];

    task automatic check_show(input string tag);
        logic [2:0] f0, f1;
        f0 = face[2:0];
        f1 = face[5:3];
        check({tag, "_f0_range"}, 32'(f0 >= 3'd1 && f0 <= 3'd6), 32'(1));
        check({tag, "_f1_range"}, 32'(f1 >= 3'd1 && f1 <= 3'd6), 32'(1));
        check({tag, "_disp0"}, 32'(display[7:0]), 32'(pip_tab[f0]));
        check({tag, "_disp1"}, 32'(display[15:8]), 32'(pip_tab[f1]));
        check({tag, "_sum_add"}, 32'(sum), 32'(f0) + 32'(f1));
    endtask

    int press_len [10] = '{10, 1, 2, 5, 3, 7, 1, 4, 12, 6};

    initial begin
        int cyc;
        int max8;
        int chg8 [8];
        logic [2:0] prev8 [8];
        logic [2:0] cur;
        logic [2:0] held0;

        pip_tab[0] = 8'h00; pip_tab[1] = 8'h02; pip_tab[2] = 8'h90; pip_tab[3] = 8'h92;
        pip_tab[4] = 8'h6C; pip_tab[5] = 8'h6E; pip_tab[6] = 8'hFC; pip_tab[7] = 8'h00;

        reset = 1'b0; roll = 1'b0; roll8 = 1'b0; hold = 2'b00;
        repeat (2) @(negedge clock);

        // Roll briefly, then reset for 3 cycles with roll still high
        reset = 1'b1; roll = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        repeat (3) step();
        check("rst_face", 32'(face), 32'(0));
        check("rst_display", 32'(display), 32'(0));
        check("rst_sum", 32'(sum), 32'(0));
        check("rst_rolling", 32'(rolling), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_state", 32'(dut.state_q), 32'(0));
        roll = 1'b0;
        reset = 1'b1;
        #1;
        check("lfsr_release", 32'(dut.lfsr_q), 32'h0000ACE1);
        step();
        check("lfsr_adv", 32'(dut.lfsr_q), 32'(m_lfsr));

        // Ten rolls with varied press lengths
        for (int r = 0; r < 10; r++) begin
            roll = 1'b1;
            repeat (press_len[r]) step();
            roll = 1'b0;
            n_done = 0;
            wait_done(cyc);
            check($sformatf("roll%0d_settle_time", r), 32'(cyc >= 8 && cyc <= 16), 32'(1));
            step(); step();
            check($sformatf("roll%0d_done_once", r), 32'(n_done), 32'(1));
            check($sformatf("roll%0d_state_show", r), 32'(dut.state_q), 32'(3));
            check_show($sformatf("roll%0d", r));
        end

        // Re-press during SETTLE restarts the settle count
        roll = 1'b1;
        repeat (3) step();
        roll = 1'b0;
        n_done = 0;
        step();
        check("settle_load", 32'(dut.settle_q), 32'(3));
        check("settle_state", 32'(dut.state_q), 32'(2));
        repeat (3) step();
        check("settle_still", 32'(dut.state_q), 32'(2));
        roll = 1'b1;
        step();
        check("repress_roll", 32'(dut.state_q), 32'(1));
        roll = 1'b0;
        step();
        check("repress_reload", 32'(dut.settle_q), 32'(3));
        check("repress_no_done", 32'(n_done), 32'(0));
        wait_done(cyc);
        step(); step();
        check("repress_done_once", 32'(n_done), 32'(1));
        check_show("repress");

`ifdef DICE_HOLD_EN
        // Hold die 0 through a full roll
        hold = 2'b01;
        held0 = face[2:0];
        roll = 1'b1;
        repeat (20) step();
        roll = 1'b0;
        wait_done(cyc);
        step();
        check("hold_frozen", 32'(face[2:0]), 32'(held0));
        hold = 2'b00;
`else
        held0 = 3'd0;
`endif

        // N_DICE=8 instance: 1000 ticks of continuous rolling
        check("sum_w8", 32'($bits(dut8.sum)), 32'(6));
        max8 = 0;
        for (int d = 0; d < 8; d++) begin
            chg8[d] = 0;
            prev8[d] = face8[3*d +: 3];
        end
        roll8 = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            if (32'(sum8) > max8) max8 = 32'(sum8);
            for (int d = 0; d < 8; d++) begin
                cur = face8[3*d +: 3];
                if (cur != prev8[d]) chg8[d]++;
                prev8[d] = cur;
            end
        end
        roll8 = 1'b0;
        check("sum8_max_le_48", 32'(max8 <= 48), 32'(1));
        check("sum8_nonzero", 32'(max8 > 0), 32'(1));
        for (int d = 0; d < 8; d++)
            check($sformatf("die8_%0d_updates", d), 32'(chg8[d] >= 2), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multi_dice_roller.md
Name: multi_dice_roller

Overview:
- Parametrised N-die roller for the board display path: one shared LFSR, a tick divider and a roll/settle/show FSM drive N_DICE independent dice.
- Each die is presented as a face value 1..6 and as the team's 8-bit pip pattern.
- Adds over the single-die block: multiple dice, a timed settle phase after button release, a face sum, and a done strobe.

Parameters:
- N_DICE, 2, number of dice (1..8).
- DIV, 500000, clock cycles per animation tick (DIV >= 2).
- SETTLE_TICKS, 20, ticks of continued rolling after roll is released (>= 1).
- SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low.
- roll  in  1  level; high = roll (pre-debounced, synchronous to clock).
- hold  in  N_DICE  per-die freeze mask; present only with DICE_HOLD_EN.
- face  out  3*N_DICE  die i face at [3i+2:3i]; 0 = blank, else 1..6.
- display  out  8*N_DICE  die i pip pattern at [8i+7:8i].
- sum  out  SUM_W  sum of faces; SUM_W = $clog2(6*N_DICE+1).
- rolling  out  1  high in ROLL and SETTLE.
- done  out  1  one-clock pulse on entering SHOW.

Behaviour:
- Reset: applied when reset==0 at posedge clock.
  - Outputs after reset: face=0, display=0, sum=0, rolling=0, done=0.
  - Internal state after reset: LFSR=SEED, divider=0, state=IDLE, settle counter=0.
- Tick: divider counts 0..DIV-1 and wraps; tick is a one-clock pulse on the wrap cycle.
- Tick timing: the divider runs freely out of reset, independent of FSM state.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock, not only on ticks, so results depend on press timing.
- Face update (on a tick in ROLL/SETTLE):
  - Die i takes slice s = LFSR[3i+2:3i] modulo the 16-bit LFSR, wrapping index mod 16.
  - If s is in 1..6, face_i <= s; else face_i keeps its value.
  - A die still at face 0 after its first update tick stays 0 until a valid slice appears.
- Pip patterns:
  - 1 = 00000010
  - 2 = 10010000
  - 3 = 10010010
  - 4 = 01101100
  - 5 = 01101110
  - 6 = 11111100
  - 0 = 00000000
  - display is combinational from face.
- sum: registered, updated the cycle after any face change; zero-extended addition of all faces.
- FSM:
  - IDLE: roll=1 -> ROLL.
  - ROLL: faces update on ticks; roll=0 -> SETTLE, load settle counter with SETTLE_TICKS.
  - SETTLE: faces update on ticks and the counter decrements per tick. roll=1 -> ROLL (re-press restarts). Counter reaching 0 on a tick -> SHOW, with done=1 that cycle.
  - SHOW: faces frozen; roll=1 -> ROLL. Faces keep old values until the first tick.
- Simultaneous events: a tick in the same cycle as a state change uses the pre-transition state's rule.
- Reset mid-roll: returns to IDLE with blank faces and no done pulse.
- rolling is a registered decode of state, so it asserts the cycle after roll is sampled.

Optional Feature:
- Macro: DICE_HOLD_EN.
- Defined: hold port exists. A die with hold[i]=1 never updates; its face and sum contribution stay frozen through ROLL/SETTLE, and hold has no other effect.
- Undefined: no hold port; all dice update.

Decomposition:
- Package dice_pkg holds:
  - FACE_W=3 and PIP_W=8.
  - The six pip localparams.
  - A face_to_pip function.
  - A state enum: IDLE, ROLL, SETTLE, SHOW.
  - LFSR tap constants.
- Sub-module dice_tick_div(clock, reset, tick), parameter DIV.

Test Plan (DIV=4, SETTLE_TICKS=3, N_DICE=2):
- Reset held 3 cycles mid-roll -> face=0, display=0, sum=0, rolling=0, state IDLE; LFSR equals 16'hACE1 the cycle after release.
- roll pulsed 1 clock then low -> ROLL, SETTLE, then SHOW after exactly 3 ticks (12±4 clocks). done high exactly 1 cycle; both faces in 1..6.
- In SHOW, check each 8-bit display slice against its face per the table, e.g. face 5 -> 01101110, and sum = face0+face1. Ten rolls with varied press lengths.
- Re-press roll during SETTLE -> returns to ROLL, no done pulse; settle restarts at 3 on release.
- N_DICE=8 build -> sum never exceeds 48 and SUM_W=6; all slices update over 1000 ticks.
- With DICE_HOLD_EN, hold=2'b01 during a roll -> die 0 face unchanged, die 1 changes. Without the macro, the build has no hold port.
